vga_scan_generator: RTL and testbench

Raster timing generator that drives the register heap display. It produces the 11-bit pixel coordinates `x`, `y` consumed by the register heap renderer, plus VGA sync and blanking signals. It also latches a per-frame snapshot of the 176-bit CPU register bus, so the renderer draws stable values for a whole frame without tearing. It sits between the CPU register file and the renderer, clocked by the 50 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/register_snapshot.sv | 42 ++++
 rtl/vga_scan_generator.sv | 91 +++++++++
 tb/tb_vga_scan_generator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared raster timing constants and snapshot state type
package vga_timing_pkg;

  localparam int COORD_W   = 11;
  localparam int REG_BUS_W = 176;
  localparam int REG_W     = 16;

  // 800x600@72 with a 50 MHz pixel clock
  localparam int DEF_H_VIS  = 800;
  localparam int DEF_H_FP   = 56;
  localparam int DEF_H_SYNC = 120;
  localparam int DEF_H_BP   = 64;
  localparam int DEF_V_VIS  = 600;
  localparam int DEF_V_FP   = 37;
  localparam int DEF_V_SYNC = 6;
  localparam int DEF_V_BP   = 23;

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

endpackage

// File: rtl/register_snapshot.sv
// rtl/register_snapshot.sv - per-frame register bus holding register (REG_SNAPSHOT_EN)
// Without REG_SNAPSHOT_EN the live bus passes straight through.
module register_snapshot
  import vga_timing_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [REG_BUS_W-1:0] registers_live,
  output logic [REG_BUS_W-1:0] registers
);

`ifdef REG_SNAPSHOT_EN
  snap_state_e          state_q;
  logic [REG_BUS_W-1:0] regs_q;

  // LIVE loads once out of reset so the first frame is not drawn from zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LIVE;
      regs_q  <= '0;
    end else begin
      case (state_q)
        LIVE: begin
          regs_q  <= registers_live;
          state_q <= HOLD;
        end
        HOLD: begin
          if (capture) regs_q <= registers_live;
        end
      endcase
    end
  end

  assign registers = regs_q;
`else
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, clk, rst, capture};
  assign registers   = registers_live;
`endif

endmodule

// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - raster counters, sync decode and frame-stable register bus
// REG_SNAPSHOT_EN selects the per-frame register snapshot in register_snapshot.
module vga_scan_generator
  import vga_timing_pkg::*;
#(
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_BUS_W-1:0] registers_live,
  output logic [COORD_W-1:0]   x,
  output logic [COORD_W-1:0]   y,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 active,
  output logic                 frame_start,
  output logic [REG_BUS_W-1:0] registers
);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  // run_q holds the counters at (0,0) for the first post-reset cycle so that
  // pixel (0,0) is presented with active/frame_start asserted
  logic               run_q, run_d;
  logic [COORD_W-1:0] hc_q, hc_d;
  logic [COORD_W-1:0] vc_q, vc_d;
  logic               line_end, frame_end;

  always_comb begin
    line_end  = (hc_q == H_LAST);
    frame_end = (vc_q == V_LAST);
    run_d     = 1'b1;
    hc_d      = hc_q;
    vc_d      = vc_q;
    if (run_q) begin
      if (line_end) begin
        hc_d = '0;
        vc_d = frame_end ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      hc_q  <= '0;
      vc_q  <= '0;
    end else begin
      run_q <= run_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
    end
  end

  logic h_vis, v_vis, h_sync_on, v_sync_on, capture;

  assign h_vis     = int'(hc_q) < H_VIS;
  assign v_vis     = int'(vc_q) < V_VIS;
  assign h_sync_on = (int'(hc_q) >= H_VIS + H_FP) && (int'(hc_q) < H_VIS + H_FP + H_SYNC);
  assign v_sync_on = (int'(vc_q) >= V_VIS + V_FP) && (int'(vc_q) < V_VIS + V_FP + V_SYNC);

  assign x           = hc_q;
  assign y           = vc_q;
  assign hsync       = (run_q && h_sync_on) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (run_q && v_sync_on) ? SYNC_POL : ~SYNC_POL;
  assign active      = run_q && h_vis && v_vis;
  assign frame_start = run_q && (hc_q == '0) && (vc_q == '0);

  // last pixel of visible video: new values land during vertical blanking
  assign capture = run_q && line_end && (int'(vc_q) == V_VIS - 1);

  register_snapshot u_register_snapshot (
    .clk            (clk),
    .rst            (rst),
    .capture        (capture),
    .registers_live (registers_live),
    .registers      (registers)
  );

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb/tb_vga_scan_generator.sv - scoreboard bench for vga_scan_generator on a reduced raster
module tb_vga_scan_generator;
  import vga_timing_pkg::*;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6, HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 3, VS = 2, VB = 3, VT = VV + VF + VS + VB;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [REG_BUS_W-1:0] live;
  logic [COORD_W-1:0]   x, y;
  logic                 hsync, vsync, active, frame_start;
  logic [REG_BUS_W-1:0] registers;

  always #5 clk = ~clk;

  vga_scan_generator #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .registers_live (live),
    .x              (x),
    .y              (y),
    .hsync          (hsync),
    .vsync          (vsync),
    .active         (active),
    .frame_start    (frame_start),
    .registers      (registers)
  );

  typedef struct packed {
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic                 hs;
    logic                 vs;
    logic                 act;
    logic                 fs;
    logic [REG_BUS_W-1:0] regs;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  bit                   m_run, m_hold;
  int                   m_hc, m_vc;
  logic [REG_BUS_W-1:0] m_regs;

  task automatic chk(input string tag, input logic [REG_BUS_W-1:0] obs,
                     input logic [REG_BUS_W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_run = 1'b0; m_hold = 1'b0; m_hc = 0; m_vc = 0; m_regs = '0;
    end else begin
      if (!m_hold) begin
        m_regs = live; m_hold = 1'b1;
      end else if (m_run && m_hc == HT - 1 && m_vc == VV - 1) begin
        m_regs = live;
      end
      if (!m_run) m_run = 1'b1;
      else if (m_hc == HT - 1) begin
        m_hc = 0;
        m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
      end else m_hc++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.x   = COORD_W'(m_hc);
    e.y   = COORD_W'(m_vc);
    e.hs  = m_run && m_hc >= HV + HF && m_hc < HV + HF + HS;
    e.vs  = m_run && m_vc >= VV + VF && m_vc < VV + VF + VS;
    e.act = m_run && m_hc < HV && m_vc < VV;
    e.fs  = m_run && m_hc == 0 && m_vc == 0;
`ifdef REG_SNAPSHOT_EN
    e.regs = m_regs;
`else
    e.regs = live;
`endif
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    sb.push_back(model_out());
    @(negedge clk);
    e = sb.pop_front();
    chk("x", x, e.x);
    chk("y", y, e.y);
    chk("hsync", hsync, e.hs);
    chk("vsync", vsync, e.vs);
    chk("active", active, e.act);
    chk("frame_start", frame_start, e.fs);
    chk("registers", registers, e.regs);
  endtask

  initial begin
    logic [REG_BUS_W-1:0] rel_live;
    int elapsed, hs_cnt, hs_first, vs_cnt, vs_first, guard, px, py;

    rst  = 1'b1;
    live = '0;
    for (int i = 0; i < 6; i++) live = {live[REG_BUS_W-33:0], 32'($urandom())};
    live[175:160] = 16'h1234;
    rel_live = live;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_active", active, 1'b0);
    chk("rst_hsync", hsync, 1'b0);
    chk("rst_vsync", vsync, 1'b0);

    rst = 1'b0;
    tick();
    chk("rel_x", x, 0);
    chk("rel_y", y, 0);
    chk("rel_active", active, 1'b1);
    chk("rel_fs", frame_start, 1'b1);
    chk("rel_regs", registers, rel_live);
    tick();
    chk("fs_one_cycle", frame_start, 1'b0);
    chk("x_step", x, 1);

    elapsed = 1; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1; guard = 0;
    while (guard < 2 * HT * VT) begin
      if (m_hc == 0 && m_vc == VV / 2) live[175:160] = 16'hBEEF;
      px = m_hc; py = m_vc;
      tick();
      guard++; elapsed++;
      if (px == HT - 1 && py == 0) begin
        chk("line_wrap_x", x, 0);
        chk("line_wrap_y", y, 1);
      end
      if (y == 0 && x == HV - 1) chk("last_visible_active", active, 1'b1);
      if (y == 0 && x == HV) chk("active_falls", active, 1'b0);
      if (y == 0 && hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(x);
      end
      if (vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(y);
      end
`ifdef REG_SNAPSHOT_EN
      if (x == HT - 1 && y == VV - 1) chk("hold_r0", registers[175:160], 16'h1234);
      if (x == 0 && y == VV) chk("capture_r0", registers[175:160], 16'hBEEF);
`endif
      if (frame_start) break;
    end
    chk("frame_period", elapsed, HT * VT);
    chk("frame_wrap_y", y, 0);
    chk("hsync_width", hs_cnt, HS);
    chk("hsync_start", hs_first, HV + HF);
    chk("vsync_cycles", vs_cnt, VS * HT);
    chk("vsync_first_line", vs_first, VV + VF);

    guard = 0;
    while (!(m_hc == 8 && m_vc == 6) && guard < 2 * HT * VT) begin
      tick();
      guard++;
    end
    chk("reach_mid_frame", (m_hc == 8 && m_vc == 6), 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst_x", x, 0);
    chk("midrst_y", y, 0);
    chk("midrst_active", active, 1'b0);
`ifdef REG_SNAPSHOT_EN
    chk("midrst_regs", registers, '0);
`endif
    live[175:160] = 16'h5A5A;
    rel_live = live;
    rst = 1'b0;
    tick();
    chk("rerel_fs", frame_start, 1'b1);
    chk("rerel_r0", registers[175:160], 16'h5A5A);

    for (int i = 0; i < 4; i++) begin
      live = ~live;
      #1;
`ifdef REG_SNAPSHOT_EN
      chk("hold_vs_toggle", registers, rel_live);
`else
      chk("comb_follow", registers, live);
`endif
      tick();
    end
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
